// File: rtl/regfile_pkg.sv
// Shared types and write-port arbitration for the multi-port register file.
// Used by regfile_mp_sb and regfile_scoreboard.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int AW_D    = $clog2(NREGS_D);
    localparam int MAXWR   = 16;

    typedef logic [AW_D-1:0]   reg_addr_t;
    typedef logic [XLEN_D-1:0] reg_data_t;

    // Highest-index set bit of the per-port hit vector wins; -1 means no hit.
    function automatic int win_port(input logic [MAXWR-1:0] hit);
        int w;
        w = -1;
        for (int i = 0; i < MAXWR; i++) begin
            if (hit[i]) w = i;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: issue sets, flush clears all, writeback clears.
// Issue beats flush, which beats writeback; register 0 is never busy.
import regfile_pkg::*;

module regfile_scoreboard #(
    parameter int NREGS = NREGS_D,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] nxt;
    logic             clr;

    always_comb begin
        nxt = busy;
        clr = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            clr = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) clr = 1'b1;
            end
            if (iss_en && iss_addr == AW'(r)) nxt[r] = 1'b1;
            else if (flush)                   nxt[r] = 1'b0;
            else if (clr)                     nxt[r] = 1'b0;
        end
        nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy <= '0;
        else        busy <= nxt;
    end

    assign busy_vec = busy;

    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_busy[p] = busy[rd_addr[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with RAW busy scoreboard; x0 reads zero.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
import regfile_pkg::*;

module regfile_mp_sb #(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  wval [NREGS];
    logic [NREGS-1:0] wsel;
    logic [MAXWR-1:0] whit;
    int               wwin;

    always_comb begin
        whit = '0;
        wwin = -1;
        for (int r = 0; r < NREGS; r++) begin
            whit = '0;
            for (int p = 0; p < NWR; p++) begin
                whit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r));
            end
            wwin    = win_port(whit);
            wsel[r] = (r != 0) && (wwin >= 0);
            wval[r] = '0;
            for (int p = 0; p < NWR; p++) begin
                if (p == wwin) wval[r] = wr_data[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wsel[r]) regs[r] <= wval[r];
            end
        end
    end

    logic [NRD-1:0] sb_busy;

    regfile_scoreboard #(
        .NREGS(NREGS),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .flush   (flush),
        .rd_addr (rd_addr),
        .busy_vec(busy_vec),
        .rd_busy (sb_busy)
    );

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0]   byp;
    logic [MAXWR-1:0] rhit;
    int               rwin;
    logic [AW-1:0]    ra;

    always_comb begin
        rd_data = '0;
        byp     = '0;
        rhit    = '0;
        rwin    = -1;
        ra      = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (ra != '0) rd_data[p*XLEN +: XLEN] = regs[ra];
            rhit = '0;
            for (int q = 0; q < NWR; q++) begin
                rhit[q] = wr_en[q] && (wr_addr[q*AW +: AW] == ra);
            end
            rwin = win_port(rhit);
            if (ra != '0 && rwin >= 0) begin
                byp[p] = 1'b1;
                for (int q = 0; q < NWR; q++) begin
                    if (q == rwin) rd_data[p*XLEN +: XLEN] = wr_data[q*XLEN +: XLEN];
                end
            end
        end
    end

    assign rd_busy = sb_busy & ~byp;
`else
    logic [AW-1:0] ra;

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (ra != '0) rd_data[p*XLEN +: XLEN] = regs[ra];
        end
    end

    assign rd_busy = sb_busy;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and randomized checks of regfile_mp_sb against a behavioural model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

    reg_data_t m_regs [32];
    logic [31:0] m_busy;

    regfile_mp_sb dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .flush   (flush),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // Architectural effect of one edge, applied from the currently driven inputs.
    task automatic model_edge();
        logic [31:0] nb;
        reg_addr_t   a;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            nb = m_busy;
            for (int p = 0; p < 2; p++) begin
                a = wr_addr[p*5 +: 5];
                if (wr_en[p]) begin
                    nb[a] = 1'b0;
                    if (a != 0) m_regs[a] = wr_data[p*32 +: 32];
                end
            end
            if (flush) nb = '0;
            if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
            m_busy = nb;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        rd_addr  = '0;
    endtask

    function automatic logic [31:0] exp_rd(int p);
        reg_addr_t   a;
        logic [31:0] v;
        a = rd_addr[p*5 +: 5];
        if (a == 0) return '0;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int q = 0; q < 2; q++) begin
            if (wr_en[q] && wr_addr[q*5 +: 5] == a) v = wr_data[q*32 +: 32];
        end
`endif
        return v;
    endfunction

    function automatic logic exp_rb(int p);
        reg_addr_t a;
        logic      b;
        a = rd_addr[p*5 +: 5];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int q = 0; q < 2; q++) begin
            if (a != 0 && wr_en[q] && wr_addr[q*5 +: 5] == a) b = 1'b0;
        end
`endif
        return b;
    endfunction

    task automatic test_reset();
        idle();
        reset   = 1'b0;
        wr_en   = 2'b11;
        wr_addr = {5'd4, 5'd4};
        wr_data = {32'h1, 32'h2};
        iss_en  = 1'b1;
        iss_addr = 5'd4;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            for (int p = 0; p < 2; p++) begin
                total++;
                if (rd_data[p*32 +: 32] !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_rd p%0d a=%0d got=%h exp=0", p, rd_addr[p*5 +: 5], rd_data[p*32 +: 32]);
                end
            end
        end
        total++;
        if (busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL reset_busy got=%h exp=0", busy_vec);
        end
        wr_en   = 2'b01;
        wr_addr = '0;
        wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        #1;
        total++;
        if (rd_data[31:0] !== 32'h0) begin
            bad++;
            $display("FAIL x0_write got=%h exp=0", rd_data[31:0]);
        end
    endtask

    task automatic test_write_priority();
        idle();
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'h22, 32'h11};
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        total++;
        if (rd_data[31:0] !== 32'h22) begin
            bad++;
            $display("FAIL prio_x5 got=%h exp=22", rd_data[31:0]);
        end
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'h33};
        tick();
        idle();
        rd_addr = {5'd7, 5'd0};
        #1;
        total++;
        if (rd_data[63:32] !== 32'h33) begin
            bad++;
            $display("FAIL write_x7 got=%h exp=33", rd_data[63:32]);
        end
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] e;
        idle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h1234};
        tick();
        wr_data = {32'h0, 32'hA5A5};
        rd_addr = {5'd9, 5'd9};
`ifdef REGFILE_BYPASS_EN
        e = 32'hA5A5;
`else
        e = 32'h1234;
`endif
        #1;
        for (int p = 0; p < 2; p++) begin
            total++;
            if (rd_data[p*32 +: 32] !== e) begin
                bad++;
                $display("FAIL same_cycle p%0d got=%h exp=%h", p, rd_data[p*32 +: 32], e);
            end
        end
        tick();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        total++;
        if (rd_data[31:0] !== 32'hA5A5) begin
            bad++;
            $display("FAIL next_cycle got=%h exp=a5a5", rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        tick();
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        total++;
        if (busy_vec[3] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL issue_x3 got=%b/%b exp=1/1", busy_vec[3], rd_busy[0]);
        end
        total++;
        if (rd_busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL rd_busy_x0 got=%b exp=0", rd_busy[1]);
        end
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd3};
        wr_data  = {32'h0, 32'h77};
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        tick();
        idle();
        #1;
        total++;
        if (busy_vec[3] !== 1'b1) begin
            bad++;
            $display("FAIL issue_beats_wb got=%b exp=1", busy_vec[3]);
        end
        wr_en   = 2'b10;
        wr_addr = {5'd3, 5'd0};
        tick();
        idle();
        #1;
        total++;
        if (busy_vec[3] !== 1'b0) begin
            bad++;
            $display("FAIL wb_clear got=%b exp=0", busy_vec[3]);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL issue_x0 got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_flush();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd4;
        tick();
        iss_addr = 5'd6;
        tick();
        iss_addr = 5'd8;
        tick();
        total++;
        if (busy_vec !== 32'h0000_0150) begin
            bad++;
            $display("FAIL issue_three got=%h exp=00000150", busy_vec);
        end
        flush    = 1'b1;
        iss_addr = 5'd10;
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0000_0400) begin
            bad++;
            $display("FAIL flush_issue got=%h exp=00000400", busy_vec);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd2};
        wr_data = {32'h0, 32'h99};
        iss_en  = 1'b1;
        iss_addr = 5'd12;
        tick();
        reset    = 1'b0;
        wr_data  = {32'h0, 32'h55};
        iss_addr = 5'd2;
        tick();
        idle();
        rd_addr = {5'd12, 5'd2};
        #1;
        total++;
        if (rd_data[31:0] !== 32'h0 || busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h/%h exp=0/0", rd_data[31:0], busy_vec);
        end
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd2};
        wr_data = {32'h0, 32'h66};
        tick();
        idle();
        rd_addr = {5'd0, 5'd2};
        #1;
        total++;
        if (rd_data[31:0] !== 32'h66) begin
            bad++;
            $display("FAIL after_reset got=%h exp=66", rd_data[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic        eb;
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 63) != 0);
            wr_en  = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                wr_addr[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                wr_data[p*32 +: 32] = $urandom;
                rd_addr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr[p*5 +: 5] : 5'($urandom_range(0, 7));
            end
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                e  = exp_rd(p);
                eb = exp_rb(p);
                total++;
                if (rd_data[p*32 +: 32] !== e) begin
                    bad++;
                    $display("FAIL rand_rd c%0d p%0d got=%h exp=%h", c, p, rd_data[p*32 +: 32], e);
                end
                total++;
                if (rd_busy[p] !== eb) begin
                    bad++;
                    $display("FAIL rand_rb c%0d p%0d got=%b exp=%b", c, p, rd_busy[p], eb);
                end
            end
            total++;
            if (busy_vec !== m_busy) begin
                bad++;
                $display("FAIL rand_busy c%0d got=%h exp=%h", c, busy_vec, m_busy);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        idle();
        test_reset();
        test_write_priority();
        test_same_cycle_read();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
